control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Pipelined control unit for the 5-stage RV32I core.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers, each stage getting only the bits it uses.
- Detects load-use hazards and applies bubble/flush/hold.
- Adds optional U-type decode, a jal link write, defined handling of illegal opcodes, and a saturating hazard-stall counter.

Parameters:
- REG_AW, 5, register-address width.
- ALUOP_W, 2, ALUOp field width; bits above [1:0] are driven 0.
- EN_UTYPE, 0, 1 enables decode of lui (0110111) and auipc (0010111).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  instr[6:0]
- id_rs1, id_rs2, id_rd  in  REG_AW each  ID register fields
- stall_ext  in  1  hold all stage registers (memory wait)
- flush  in  1  branch/jump taken, resolved in EX
- hazard_stall  out  1  load-use stall; fetch and the IF/ID register must hold
- id_illegal  out  1  valid, unrecognised opcode in ID (combinational)
- ex_alu_op  out  ALUOP_W
- ex_alu_src, ex_branch, ex_jump  out  1 each
- mem_read, mem_write  out  1 each
- wb_reg_write, wb_mem_to_reg  out  1 each
- ex_rd, mem_rd, wb_rd  out  REG_AW each  destinations, for forwarding
- ex_reg_write, mem_reg_write  out  1 each  for forwarding
- stall_cnt  out  CNT_W  hazard-stall cycles

Behaviour:
- Reset: every registered output and stall_cnt go to 0 on the first clock edge with reset high. Reset overrides all other inputs.
- Decode (combinational, in the ID stage). Fields are Branch/MemRead/MemtoReg/ALUOp/MemWrite/ALUSrc/RegWrite/Jump:
  - R 0110011 = 0/0/0/10/0/0/1/0
  - load 0000011 = 0/1/1/00/0/1/1/0
  - I 0010011 = 0/0/0/10/0/1/1/0
  - S 0100011 = 0/0/0/00/1/1/0/0
  - jalr 1100111 = 0/0/0/11/0/1/1/1
  - SB 1100011 = 1/0/0/01/0/0/0/0
  - jal 1101111 = 1/0/0/11/0/0/1/1 (RegWrite=1, the link write)
  - lui/auipc, when EN_UTYPE=1: ALUOp=11, ALUSrc=1, RegWrite=1, all other fields 0.
- Any other opcode, or id_valid=0: all-zero bundle (bubble). id_illegal = id_valid AND unrecognised. No value is retained from earlier decodes.
- rs1 is used by every class except jal/lui/auipc. rs2 is used by R, S and SB only.
- Load-use hazard: hazard_stall = ex mem_read AND ex_rd!=0 AND ((rs1 used AND ex_rd==id_rs1) OR (rs2 used AND ex_rd==id_rs2)) AND id_valid AND NOT flush.
- Latency: a bundle in ID at edge t appears on ex_* after t+1, mem_* after t+2, wb_* after t+3.
- Per-edge priority: reset > flush > stall_ext > hazard_stall > normal advance.
  - flush: ID/EX and EX/MEM load bubbles (all control and rd = 0); MEM/WB advances normally.
  - stall_ext (no flush): all three registers hold.
  - hazard_stall: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - normal: ID->EX->MEM->WB shift.
- Bubble definition: every control bit 0, rd 0. A bubble never writes registers or memory.
- stall_cnt increments on each edge where hazard_stall=1 and stall_ext=0. It saturates at all-ones and never wraps.
- With flush and stall_ext both high, flush wins; the younger instructions are killed even while held.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams;
  - ALUOp encodings ALUOP_ADD=00, ALUOP_BR=01, ALUOP_FUNCT=10, ALUOP_PASS=11;
  - packed struct ctrl_t with the 8 fields;
  - constant CTRL_BUBBLE.
- One sub-module, ctrl_decode: combinational opcode -> ctrl_t, rs-use flags, illegal. The three stage registers and the hazard logic stay in control_pipe.

Test Plan:
- R-type add (rd=5) with stalls and flush low: ex_alu_op=10 after 1 cycle, wb_reg_write=1 and wb_rd=5 after 3 cycles.
- lw x6 followed by add x7,x6,x1: hazard_stall=1 for exactly 1 cycle, ex_* shows a bubble, stall_cnt=1, then add reaches EX with ex_alu_op=10.
- lw x0 followed by use of x0: hazard_stall stays 0. lw x6 followed by jal: hazard_stall stays 0.
- flush asserted with sw in ID and add in EX: next cycle ex_* and mem_* are all 0 (mem_write=0); the prior MEM instruction reaches WB unchanged.
- stall_ext high for 3 cycles: all outputs frozen. stall_ext together with flush: bubbles are inserted.
- Opcode 0110111 with EN_UTYPE=0: id_illegal=1 and the bundle is 0. With EN_UTYPE=1: reg_write=1, alu_src=1.
- CNT_W=2 with 5 hazards: stall_cnt saturates at 3.
- Reset mid-stream: all outputs 0 after one edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I pipelined control unit.
// Holds the opcode and ALUOp encodings, the per-stage control bundles, their
// bubble values and the helpers that narrow a bundle as it moves down the pipe.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  // Full bundle produced by decode and held in ID/EX.
  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

  // Subset still needed once the instruction has left EX.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  // Subset still needed in WB.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ctrl_t     CTRL_BUBBLE = '0;
  localparam mem_ctrl_t MEM_BUBBLE  = '0;
  localparam wb_ctrl_t  WB_BUBBLE   = '0;

  function automatic ctrl_t ctrl_make(
    input logic       branch,
    input logic       mem_read,
    input logic       mem_to_reg,
    input logic [1:0] alu_op,
    input logic       mem_write,
    input logic       alu_src,
    input logic       reg_write,
    input logic       jump
  );
    ctrl_t c;
    c.branch     = branch;
    c.mem_read   = mem_read;
    c.mem_to_reg = mem_to_reg;
    c.alu_op     = alu_op;
    c.mem_write  = mem_write;
    c.alu_src    = alu_src;
    c.reg_write  = reg_write;
    c.jump       = jump;
    return c;
  endfunction

  function automatic mem_ctrl_t to_mem(input ctrl_t c);
    mem_ctrl_t m;
    m.mem_read   = c.mem_read;
    m.mem_write  = c.mem_write;
    m.reg_write  = c.reg_write;
    m.mem_to_reg = c.mem_to_reg;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
    wb_ctrl_t w;
    w.reg_write  = m.reg_write;
    w.mem_to_reg = m.mem_to_reg;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage opcode decoder.
// Ports:
//   valid_i    - ID holds a real instruction
//   opcode_i   - instr[6:0]
//   ctrl_o     - control bundle (all zero for invalid or unrecognised opcodes)
//   rs1_used_o - instruction reads rs1
//   rs2_used_o - instruction reads rs2
//   known_o    - valid and recognised (its rd field is meaningful)
//   illegal_o  - valid but unrecognised
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_UTYPE = 1'b0
) (
  input  logic       valid_i,
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o,
  output logic       known_o,
  output logic       illegal_o
);

  ctrl_t ctl;
  logic  rs1_used;
  logic  rs2_used;
  logic  recognised;

  always_comb begin
    ctl        = CTRL_BUBBLE;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    recognised = 1'b1;
    case (opcode_i)
      OPC_R: begin
        ctl      = ctrl_make(1'b0, 1'b0, 1'b0, ALUOP_FUNCT, 1'b0, 1'b0, 1'b1, 1'b0);
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        ctl      = ctrl_make(1'b0, 1'b1, 1'b1, ALUOP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
        rs1_used = 1'b1;
      end
      OPC_IMM: begin
        ctl      = ctrl_make(1'b0, 1'b0, 1'b0, ALUOP_FUNCT, 1'b0, 1'b1, 1'b1, 1'b0);
        rs1_used = 1'b1;
      end
      OPC_STORE: begin
        ctl      = ctrl_make(1'b0, 1'b0, 1'b0, ALUOP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_JALR: begin
        ctl      = ctrl_make(1'b0, 1'b0, 1'b0, ALUOP_PASS, 1'b0, 1'b1, 1'b1, 1'b1);
        rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        ctl      = ctrl_make(1'b1, 1'b0, 1'b0, ALUOP_BR, 1'b0, 1'b0, 1'b0, 1'b0);
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      // jal writes the link register and reads no source register.
      OPC_JAL: begin
        ctl = ctrl_make(1'b1, 1'b0, 1'b0, ALUOP_PASS, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      OPC_LUI, OPC_AUIPC: begin
        if (EN_UTYPE) begin
          ctl = ctrl_make(1'b0, 1'b0, 1'b0, ALUOP_PASS, 1'b0, 1'b1, 1'b1, 1'b0);
        end else begin
          recognised = 1'b0;
        end
      end
      default: recognised = 1'b0;
    endcase

    // Invalid slots and unknown opcodes collapse to a bubble that reads nothing,
    // so they can never trigger a load-use stall.
    if (!valid_i || !recognised) begin
      ctl      = CTRL_BUBBLE;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
    end
  end

  assign ctrl_o     = ctl;
  assign rs1_used_o = rs1_used;
  assign rs2_used_o = rs2_used;
  assign known_o    = valid_i && recognised;
  assign illegal_o  = valid_i && !recognised;

endmodule

// File: rtl/control_pipe.sv
// Pipelined control unit for a 5-stage RV32I core.
// Decodes the ID opcode, carries the control bundle through ID/EX (p0),
// EX/MEM (p1) and MEM/WB (p2), detects load-use hazards and counts stalls.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   id_valid, id_opcode   - ID instruction presence and opcode
//   id_rs1/rs2/rd         - ID register fields
//   stall_ext             - hold every stage register
//   flush                 - kill the instructions in ID and EX
//   hazard_stall          - load-use stall request to IF/ID
//   id_illegal            - valid but unrecognised opcode in ID
//   ex_* / mem_* / wb_*   - per-stage control and destination registers
//   stall_cnt             - saturating count of hazard-stall cycles
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 2,
  parameter int EN_UTYPE = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               stall_ext,
  input  logic               flush,
  output logic               hazard_stall,
  output logic               id_illegal,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [REG_AW-1:0]  mem_rd,
  output logic [REG_AW-1:0]  wb_rd,
  output logic               ex_reg_write,
  output logic               mem_reg_write,
  output logic [CNT_W-1:0]   stall_cnt
);

  ctrl_t id_ctl;
  logic  id_rs1_used;
  logic  id_rs2_used;
  logic  id_known;

  ctrl_decode #(
    .EN_UTYPE (EN_UTYPE != 0)
  ) u_decode (
    .valid_i    (id_valid),
    .opcode_i   (id_opcode),
    .ctrl_o     (id_ctl),
    .rs1_used_o (id_rs1_used),
    .rs2_used_o (id_rs2_used),
    .known_o    (id_known),
    .illegal_o  (id_illegal)
  );

  ctrl_t             ctl_p0_q, ctl_p0_d;
  logic [REG_AW-1:0] rd_p0_q,  rd_p0_d;
  mem_ctrl_t         ctl_p1_q, ctl_p1_d;
  logic [REG_AW-1:0] rd_p1_q,  rd_p1_d;
  wb_ctrl_t          ctl_p2_q, ctl_p2_d;
  logic [REG_AW-1:0] rd_p2_q,  rd_p2_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  // A load to x0 never produces a value worth waiting for.
  logic ex_load_dst;
  assign ex_load_dst = ctl_p0_q.mem_read && (rd_p0_q != '0);

  assign hazard_stall = ex_load_dst && id_valid && !flush &&
                        ((id_rs1_used && (rd_p0_q == id_rs1)) ||
                         (id_rs2_used && (rd_p0_q == id_rs2)));

  always_comb begin
    ctl_p0_d = ctl_p0_q;
    rd_p0_d  = rd_p0_q;
    ctl_p1_d = ctl_p1_q;
    rd_p1_d  = rd_p1_q;
    ctl_p2_d = ctl_p2_q;
    rd_p2_d  = rd_p2_q;
    cnt_d    = cnt_q;

    if (flush) begin
      // Flush beats stall_ext: the older instruction in MEM still retires.
      ctl_p0_d = CTRL_BUBBLE;
      rd_p0_d  = '0;
      ctl_p1_d = MEM_BUBBLE;
      rd_p1_d  = '0;
      ctl_p2_d = to_wb(ctl_p1_q);
      rd_p2_d  = rd_p1_q;
    end else if (!stall_ext) begin
      ctl_p2_d = to_wb(ctl_p1_q);
      rd_p2_d  = rd_p1_q;
      ctl_p1_d = to_mem(ctl_p0_q);
      rd_p1_d  = rd_p0_q;
      if (hazard_stall) begin
        ctl_p0_d = CTRL_BUBBLE;
        rd_p0_d  = '0;
      end else begin
        ctl_p0_d = id_ctl;
        rd_p0_d  = id_known ? id_rd : '0;
      end
    end

    if (hazard_stall && !stall_ext && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_p0_q <= CTRL_BUBBLE;
      rd_p0_q  <= '0;
      ctl_p1_q <= MEM_BUBBLE;
      rd_p1_q  <= '0;
      ctl_p2_q <= WB_BUBBLE;
      rd_p2_q  <= '0;
      cnt_q    <= '0;
    end else begin
      ctl_p0_q <= ctl_p0_d;
      rd_p0_q  <= rd_p0_d;
      ctl_p1_q <= ctl_p1_d;
      rd_p1_q  <= rd_p1_d;
      ctl_p2_q <= ctl_p2_d;
      rd_p2_q  <= rd_p2_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---- EX stage outputs (from ID/EX) ----
  always_comb begin
    ex_alu_op      = '0;
    ex_alu_op[1:0] = ctl_p0_q.alu_op;
  end
  assign ex_alu_src    = ctl_p0_q.alu_src;
  assign ex_branch     = ctl_p0_q.branch;
  assign ex_jump       = ctl_p0_q.jump;
  assign ex_reg_write  = ctl_p0_q.reg_write;
  assign ex_rd         = rd_p0_q;

  // ---- MEM stage outputs (from EX/MEM) ----
  assign mem_read      = ctl_p1_q.mem_read;
  assign mem_write     = ctl_p1_q.mem_write;
  assign mem_reg_write = ctl_p1_q.reg_write;
  assign mem_rd        = rd_p1_q;

  // ---- WB stage outputs (from MEM/WB) ----
  assign wb_reg_write  = ctl_p2_q.reg_write;
  assign wb_mem_to_reg = ctl_p2_q.mem_to_reg;
  assign wb_rd         = rd_p2_q;

  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: two instances (default, and U-type enabled with a
// 2-bit stall counter) share stimulus and are compared against a table-driven
// model of the control pipeline.
module tb_control_pipe;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       stall_ext = 1'b0;
  logic       flush = 1'b0;

  // Instance A: EN_UTYPE=0, CNT_W=16
  logic        hz_a, ill_a, asrc_a, br_a, jmp_a, mrd_a, mwr_a, wrw_a, wm2r_a, erw_a, mrw_a;
  logic [1:0]  aop_a;
  logic [4:0]  erd_a, mrd5_a, wrd_a;
  logic [15:0] cnt_a;
  // Instance B: EN_UTYPE=1, CNT_W=2
  logic        hz_b, ill_b, asrc_b, br_b, jmp_b, mrd_b, mwr_b, wrw_b, wm2r_b, erw_b, mrw_b;
  logic [1:0]  aop_b;
  logic [4:0]  erd_b, mrd5_b, wrd_b;
  logic [1:0]  cnt_b;

  control_pipe #(.REG_AW(5), .ALUOP_W(2), .EN_UTYPE(0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .stall_ext(stall_ext), .flush(flush),
    .hazard_stall(hz_a), .id_illegal(ill_a), .ex_alu_op(aop_a), .ex_alu_src(asrc_a),
    .ex_branch(br_a), .ex_jump(jmp_a), .mem_read(mrd_a), .mem_write(mwr_a),
    .wb_reg_write(wrw_a), .wb_mem_to_reg(wm2r_a), .ex_rd(erd_a), .mem_rd(mrd5_a),
    .wb_rd(wrd_a), .ex_reg_write(erw_a), .mem_reg_write(mrw_a), .stall_cnt(cnt_a));

  control_pipe #(.REG_AW(5), .ALUOP_W(2), .EN_UTYPE(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .stall_ext(stall_ext), .flush(flush),
    .hazard_stall(hz_b), .id_illegal(ill_b), .ex_alu_op(aop_b), .ex_alu_src(asrc_b),
    .ex_branch(br_b), .ex_jump(jmp_b), .mem_read(mrd_b), .mem_write(mwr_b),
    .wb_reg_write(wrw_b), .wb_mem_to_reg(wm2r_b), .ex_rd(erd_b), .mem_rd(mrd5_b),
    .wb_rd(wrd_b), .ex_reg_write(erw_b), .mem_reg_write(mrw_b), .stall_cnt(cnt_b));

  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_I = 7'b0010011,
                         OP_S = 7'b0100011, OP_JALR = 7'b1100111, OP_SB = 7'b1100011,
                         OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // Instruction-class table: opcode, then Branch MemRead MemtoReg ALUOp[2]
  // MemWrite ALUSrc RegWrite Jump, then rs1-used rs2-used.
  logic [6:0]  ops  [9] = '{OP_R, OP_LD, OP_I, OP_S, OP_JALR, OP_SB, OP_JAL, OP_LUI, OP_AUIPC};
  logic [10:0] rows [9] = '{11'b000_10_0010_11,   // R
                            11'b011_00_0110_10,   // load
                            11'b000_10_0110_10,   // I
                            11'b000_00_1100_11,   // S
                            11'b000_11_0111_10,   // jalr
                            11'b100_01_0000_11,   // SB
                            11'b100_11_0011_00,   // jal
                            11'b000_11_0110_00,   // lui (U-type only)
                            11'b000_11_0110_00};  // auipc (U-type only)

  typedef struct packed {
    logic       br, mrd, m2r;
    logic [1:0] aop;
    logic       mwr, asrc, rw, jmp;
    logic [4:0] rd;
  } rec_t;

  rec_t m_ex [2], m_mem [2], m_wb [2];
  int   m_cnt [2];
  int   cnt_max [2] = '{65535, 3};

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_decode(input int m, input logic v, input logic [6:0] op, input logic [4:0] rd,
                            output rec_t r, output logic u1, output logic u2, output logic ill);
    logic found;
    r = '0; u1 = 1'b0; u2 = 1'b0; found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (op == ops[i] && (i < 7 || m == 1)) begin
        found = 1'b1;
        r  = {rows[i][10:2], rd};
        u1 = rows[i][1];
        u2 = rows[i][0];
      end
    end
    ill = v && !found;
    if (!v || !found) begin
      r = '0; u1 = 1'b0; u2 = 1'b0;
    end
  endtask

  task automatic check_regs(input int m);
    string p;
    p = $sformatf("d%0d c%0d", m, cyc);
    if (m == 0) begin
      chk({p, " ex"},  {aop_a, asrc_a, br_a, jmp_a, erw_a, erd_a},
          {m_ex[0].aop, m_ex[0].asrc, m_ex[0].br, m_ex[0].jmp, m_ex[0].rw, m_ex[0].rd});
      chk({p, " mem"}, {mrd_a, mwr_a, mrw_a, mrd5_a},
          {m_mem[0].mrd, m_mem[0].mwr, m_mem[0].rw, m_mem[0].rd});
      chk({p, " wb"},  {wrw_a, wm2r_a, wrd_a}, {m_wb[0].rw, m_wb[0].m2r, m_wb[0].rd});
      chk({p, " cnt"}, 32'(cnt_a), 32'(m_cnt[0]));
    end else begin
      chk({p, " ex"},  {aop_b, asrc_b, br_b, jmp_b, erw_b, erd_b},
          {m_ex[1].aop, m_ex[1].asrc, m_ex[1].br, m_ex[1].jmp, m_ex[1].rw, m_ex[1].rd});
      chk({p, " mem"}, {mrd_b, mwr_b, mrw_b, mrd5_b},
          {m_mem[1].mrd, m_mem[1].mwr, m_mem[1].rw, m_mem[1].rd});
      chk({p, " wb"},  {wrw_b, wm2r_b, wrd_b}, {m_wb[1].rw, m_wb[1].m2r, m_wb[1].rd});
      chk({p, " cnt"}, 32'(cnt_b), 32'(m_cnt[1]));
    end
  endtask

  // One clock: drive at negedge, check ID-stage outputs, advance the model,
  // then check the registered outputs just after the rising edge.
  task automatic cycle(input logic rst, input logic v, input logic [6:0] op,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic stx, input logic fl);
    rec_t dec;
    logic u1, u2, ill, haz;
    @(negedge clk);
    reset = rst; id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    stall_ext = stx; flush = fl;
    #1;
    for (int m = 0; m < 2; m++) begin
      ref_decode(m, v, op, rd, dec, u1, u2, ill);
      haz = m_ex[m].mrd && (m_ex[m].rd != 0) && v && !fl &&
            ((u1 && m_ex[m].rd == r1) || (u2 && m_ex[m].rd == r2));
      if (!rst) begin
        chk($sformatf("d%0d c%0d hazard", m, cyc), 32'(m == 0 ? hz_a : hz_b), 32'(haz));
        chk($sformatf("d%0d c%0d illegal", m, cyc), 32'(m == 0 ? ill_a : ill_b), 32'(ill));
      end
      if (rst) begin
        m_ex[m] = '0; m_mem[m] = '0; m_wb[m] = '0; m_cnt[m] = 0;
      end else if (fl) begin
        m_wb[m] = m_mem[m]; m_mem[m] = '0; m_ex[m] = '0;
      end else if (!stx) begin
        m_wb[m] = m_mem[m]; m_mem[m] = m_ex[m];
        m_ex[m] = haz ? rec_t'('0) : dec;
        if (haz && m_cnt[m] < cnt_max[m]) m_cnt[m]++;
      end
    end
    @(posedge clk);
    #1;
    check_regs(0);
    check_regs(1);
    cyc++;
  endtask

  initial begin
    int pick;
    logic [6:0] rop;
    for (int m = 0; m < 2; m++) begin
      m_ex[m] = '0; m_mem[m] = '0; m_wb[m] = '0; m_cnt[m] = 0;
    end
    cycle(1, 0, 7'h0, 0, 0, 0, 0, 0);
    cycle(1, 0, 7'h0, 0, 0, 0, 0, 0);
    // add x5 through the pipe
    cycle(0, 1, OP_R, 1, 2, 5, 0, 0);
    cycle(0, 0, 7'h0, 0, 0, 0, 0, 0);
    cycle(0, 0, 7'h0, 0, 0, 0, 0, 0);
    // lw x6; add x7,x6,x1 (held in ID one extra cycle by the stall)
    cycle(0, 1, OP_LD, 1, 0, 6, 0, 0);
    cycle(0, 1, OP_R, 6, 1, 7, 0, 0);
    cycle(0, 1, OP_R, 6, 1, 7, 0, 0);
    // lw x0 then use of x0; lw x6 then jal
    cycle(0, 1, OP_LD, 1, 0, 0, 0, 0);
    cycle(0, 1, OP_R, 0, 0, 3, 0, 0);
    cycle(0, 1, OP_LD, 1, 0, 6, 0, 0);
    cycle(0, 1, OP_JAL, 6, 6, 1, 0, 0);
    // add in EX, sw in ID, flush
    cycle(0, 1, OP_R, 1, 2, 4, 0, 0);
    cycle(0, 1, OP_S, 2, 3, 0, 0, 1);
    // stall_ext for 3 cycles, then stall_ext together with flush
    cycle(0, 1, OP_LD, 2, 0, 9, 0, 0);
    cycle(0, 1, OP_I, 3, 0, 10, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, OP_R, 9, 9, 11, 1, 0);
    cycle(0, 1, OP_R, 9, 9, 11, 1, 1);
    // lui: illegal on A, legal on B
    cycle(0, 1, OP_LUI, 0, 0, 12, 0, 0);
    cycle(0, 1, OP_AUIPC, 0, 0, 13, 0, 0);
    // five load-use hazards drive the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, OP_LD, 1, 0, 8, 0, 0);
      cycle(0, 1, OP_SB, 2, 8, 0, 0, 0);
      cycle(0, 1, OP_SB, 2, 8, 0, 0, 0);
    end
    // reset mid-stream
    cycle(0, 1, OP_LD, 1, 0, 5, 0, 0);
    cycle(1, 1, OP_R, 5, 5, 6, 0, 0);
    // random traffic with small register indices so hazards are common
    for (int n = 0; n < 3000; n++) begin
      pick = $urandom_range(0, 11);
      if (pick >= 10) rop = OP_LD;
      else if (pick == 9) rop = 7'($urandom);
      else rop = ops[pick];
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), rop,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
